// File: rtl/gbc_ppu_pkg.sv
// Shared types and default timing constants for the PPU mode sequencer.
package gbc_ppu_pkg;

    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        DRAW     = 2'd3
    } ppu_mode_e;

    localparam int DEF_DOTS_PER_LINE = 456;
    localparam int DEF_VISIBLE_LINES = 144;
    localparam int DEF_TOTAL_LINES   = 154;
    localparam int DEF_OAM_DOTS      = 80;
    localparam int DEF_MODE3_MIN     = 172;
    localparam int DEF_MODE3_MAX     = 289;

    // Dots at the start of the last line during which LY still shows its true value.
    localparam int LY153_DOTS = 4;

    // STAT[6:3] interrupt selects
    typedef struct packed {
        logic lyc;
        logic mode2;
        logic mode1;
        logic mode0;
    } stat_sel_t;

endpackage

// File: rtl/ISysCon.sv
// System clock / reset bundle shared by the PPU blocks.
interface ISysCon;
    logic CLK;
    logic RST;

    modport master (output CLK, output RST);
    modport slave  (input  CLK, input  RST);
endinterface

// File: rtl/gbc_stat_irq_gen.sv
// STAT interrupt line and its rising-edge pulse.
// Sources are OR-ed into one line, so a source that rises while another
// already holds the line high does not produce a new pulse.
module gbc_stat_irq_gen
    import gbc_ppu_pkg::*;
(
    ISysCon.slave       SysCon,
    input  logic        Clear,
    input  logic [1:0]  Mode,
    input  logic        LycMatch,
    input  logic [3:0]  StatSel,
    output logic        StatIrq
);

    stat_sel_t sel;
    ppu_mode_e mode_e;
    logic      stat_line;
    logic      stat_line_q;

    assign sel    = stat_sel_t'(StatSel);
    assign mode_e = ppu_mode_e'(Mode);

    // Combine the enabled interrupt sources into the STAT line
    always_comb begin
        stat_line = (sel.lyc   & LycMatch)
                  | (sel.mode2 & (mode_e == OAM_SCAN))
                  | (sel.mode1 & (mode_e == VBLANK))
                  | (sel.mode0 & (mode_e == HBLANK));
    end

    // Remember the previous line level and pulse on its 0->1 edge
    always_ff @(posedge SysCon.CLK) begin
        if (SysCon.RST || Clear) begin
            stat_line_q <= 1'b0;
            StatIrq     <= 1'b0;
        end else begin
            stat_line_q <= stat_line;
            StatIrq     <= stat_line & ~stat_line_q;
        end
    end

endmodule

// File: rtl/gbc_ppu_mode_sequencer.sv
// Dot/line scheduler for the GBC PPU: mode sequencing, LY / dot counters,
// VRAM/OAM locks and the VBlank / STAT / line-start pulses.
// Optional: GBC_LY153_QUIRK_EN makes LY read 0 after the first few dots of
// the last line of the frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HBLANK   | mode 0: after draw until line end; also LCD off and the
//          | OAM-scan slot of the first line after the LCD turns on
// VBLANK   | mode 1: lines VISIBLE_LINES..TOTAL_LINES-1
// OAM_SCAN | mode 2: dots 0..OAM_DOTS-1 of a visible line
// DRAW     | mode 3: from dot OAM_DOTS until Mode3Done or the forced end
module gbc_ppu_mode_sequencer
    import gbc_ppu_pkg::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
    parameter int OAM_DOTS      = DEF_OAM_DOTS,
    parameter int MODE3_MIN     = DEF_MODE3_MIN,
    parameter int MODE3_MAX     = DEF_MODE3_MAX
) (
    ISysCon.slave       SysCon,
    input  logic        ClkEn,
    input  logic        LcdEnable,
    input  logic [7:0]  Lyc,
    input  logic [3:0]  StatSel,
    input  logic        Mode3Done,
    output logic [1:0]  Mode,
    output logic [7:0]  Ly,
    output logic [8:0]  Dot,
    output logic        LycMatch,
    output logic [2:0]  VideoStatus,
    output logic        OamLock,
    output logic        VramLock,
    output logic        LineStart,
    output logic        VBlankIrq,
    output logic        StatIrq
);

    localparam logic [1:0] ST_HBLANK   = HBLANK;
    localparam logic [1:0] ST_VBLANK   = VBLANK;
    localparam logic [1:0] ST_OAM_SCAN = OAM_SCAN;
    localparam logic [1:0] ST_DRAW     = DRAW;

    localparam logic [8:0] DOT_LAST     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_OAM_END  = 9'(OAM_DOTS);
    localparam logic [8:0] DOT_DRAW_MIN = 9'(OAM_DOTS + MODE3_MIN - 1);
    localparam logic [8:0] DOT_DRAW_MAX = 9'(OAM_DOTS + MODE3_MAX - 1);
    localparam logic [7:0] LY_LAST      = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LY_VBLANK    = 8'(VISIBLE_LINES);

    logic [8:0] dot_q,  dot_nx;
    logic [7:0] ly_q,   ly_nx;
    logic [7:0] ly_disp_q, ly_disp_nx;
    logic [1:0] mode_q, mode_nx;
    logic       first_q, first_nx;   // first line after LCD on: no OAM scan
    logic       adv_q;               // the previous edge advanced the dot
    logic       lyc_match_q;
    logic       oam_lock_q, vram_lock_q;
    logic       line_start_q, vblank_irq_q;
    logic       dot_wrap, draw_end;

    // Next dot/line/mode; everything holds when ClkEn is low
    always_comb begin
        dot_wrap   = (dot_q == DOT_LAST);
        draw_end   = (Mode3Done && (dot_q >= DOT_DRAW_MIN)) || (dot_q >= DOT_DRAW_MAX);
        dot_nx     = dot_q;
        ly_nx      = ly_q;
        first_nx   = first_q;
        mode_nx    = mode_q;
        ly_disp_nx = ly_disp_q;
        if (ClkEn) begin
            dot_nx   = dot_wrap ? 9'd0 : dot_q + 9'd1;
            ly_nx    = dot_wrap ? ((ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1) : ly_q;
            first_nx = first_q & ~dot_wrap;
            if (ly_nx >= LY_VBLANK)
                mode_nx = ST_VBLANK;
            else if (dot_nx < DOT_OAM_END)
                mode_nx = first_nx ? ST_HBLANK : ST_OAM_SCAN;
            else if (dot_nx == DOT_OAM_END)
                mode_nx = ST_DRAW;
            else if ((mode_q == ST_DRAW) && !draw_end)
                mode_nx = ST_DRAW;
            else
                mode_nx = ST_HBLANK;
            ly_disp_nx = ly_nx;
`ifdef GBC_LY153_QUIRK_EN
            if ((ly_nx == LY_LAST) && (dot_nx >= 9'(LY153_DOTS)))
                ly_disp_nx = 8'd0;
`endif
        end
    end

    // Timing state and registered outputs; LCD off forces the idle state
    always_ff @(posedge SysCon.CLK) begin
        if (SysCon.RST || !LcdEnable) begin
            dot_q        <= 9'd0;
            ly_q         <= 8'd0;
            ly_disp_q    <= 8'd0;
            mode_q       <= ST_HBLANK;
            first_q      <= 1'b1;
            adv_q        <= 1'b0;
            lyc_match_q  <= (Lyc == 8'd0);
            oam_lock_q   <= 1'b0;
            vram_lock_q  <= 1'b0;
            line_start_q <= 1'b0;
            vblank_irq_q <= 1'b0;
        end else begin
            dot_q        <= dot_nx;
            ly_q         <= ly_nx;
            ly_disp_q    <= ly_disp_nx;
            mode_q       <= mode_nx;
            first_q      <= first_nx;
            adv_q        <= ClkEn;
            lyc_match_q  <= (ly_disp_nx == Lyc);
            oam_lock_q   <= (mode_nx == ST_OAM_SCAN) || (mode_nx == ST_DRAW);
            vram_lock_q  <= (mode_nx == ST_DRAW);
            line_start_q <= adv_q && (dot_q == 9'd0) && (ly_q < LY_VBLANK);
            vblank_irq_q <= adv_q && (dot_q == 9'd0) && (ly_q == LY_VBLANK);
        end
    end

    gbc_stat_irq_gen u_stat_irq_gen (
        .SysCon   (SysCon),
        .Clear    (!LcdEnable),
        .Mode     (mode_q),
        .LycMatch (lyc_match_q),
        .StatSel  (StatSel),
        .StatIrq  (StatIrq)
    );

    assign Mode        = mode_q;
    assign Ly          = ly_disp_q;
    assign Dot         = dot_q;
    assign LycMatch    = lyc_match_q;
    assign VideoStatus = {lyc_match_q, mode_q};
    assign OamLock     = oam_lock_q;
    assign VramLock    = vram_lock_q;
    assign LineStart   = line_start_q;
    assign VBlankIrq   = vblank_irq_q;

endmodule

// File: doc/gbc_ppu_mode_sequencer.md
# gbc_ppu_mode_sequencer

Dot/line timing scheduler for the Game Boy Color pixel processing unit. Sequences the PPU through its modes: OAM scan, draw, HBlank and VBlank. Maintains LY and the dot counter, and drives the VRAM/OAM access locks used by the system bus arbitration. Generates VBlank and STAT interrupt pulses and the 3-bit VideoStatus, and sits beside the PPU register file and pixel fetcher, advancing one dot per ClkEn.

## Interface
Parameters:
- DOTS_PER_LINE, 456, dots per scanline
- VISIBLE_LINES, 144, lines with modes 2/3/0
- TOTAL_LINES, 154, lines per frame
- OAM_DOTS, 80, mode 2 length
- MODE3_MIN, 172, earliest draw end, counted from dot OAM_DOTS
- MODE3_MAX, 289, forced draw end, counted from dot OAM_DOTS

Ports (one clock, `SysCon.CLK`; reset `SysCon.RST` is synchronous and active-high, both carried in the `ISysCon SysCon` bundle):
- SysCon.CLK  input  1  system clock
- SysCon.RST  input  1  synchronous active-high reset
- ClkEn  input  1  dot enable; state advances only when high
- LcdEnable  input  1  LCDC bit 7
- Lyc  input  8  LY compare register
- StatSel  input  4  STAT[6:3] = {LYC, mode2, mode1, mode0} interrupt selects
- Mode3Done  input  1  pixel pipeline finished the line
- Mode  output  2  0 HBlank, 1 VBlank, 2 OAM scan, 3 draw
- Ly  output  8  current line as read at $FF44
- Dot  output  9  dot within line, 0..DOTS_PER_LINE-1
- LycMatch  output  1  Ly == Lyc
- VideoStatus  output  3  {LycMatch, Mode}
- OamLock  output  1  CPU OAM access blocked
- VramLock  output  1  CPU VRAM access blocked
- LineStart  output  1  one-cycle pulse at dot 0 of lines 0..VISIBLE_LINES-1
- VBlankIrq  output  1  one-cycle pulse
- StatIrq  output  1  one-cycle pulse

## Operation
- Reset, or LcdEnable low: Dot=0, Ly=0, Mode=0, LycMatch=(Lyc==0), locks low, all pulses low. The internal STAT line is cleared.
- Dot increments on ClkEn. At DOTS_PER_LINE-1 it wraps to 0 and Ly increments; Ly wraps from TOTAL_LINES-1 to 0.
- Visible line mode sequence:
  - Mode 2 for dots 0..OAM_DOTS-1.
  - Mode 3 from dot OAM_DOTS.
  - Mode 3 ends (Mode 0) on the first ClkEn where Mode3Done=1 and Dot ≥ OAM_DOTS+MODE3_MIN-1. It is forced to end at Dot = OAM_DOTS+MODE3_MAX-1 if Mode3Done never comes.
  - Mode 0 lasts until line end.
- Lines VISIBLE_LINES..TOTAL_LINES-1 are Mode 1 throughout. VBlankIrq pulses on entry to Ly=VISIBLE_LINES, dot 0.
- First line after LcdEnable rises: dots 0..OAM_DOTS-1 report Mode 0 with OamLock low, then follow normal mode 3/0 sequencing.
- OamLock = Mode∈{2,3}; VramLock = Mode==3.
- StatLine = (StatSel[3]&LycMatch)|(StatSel[2]&Mode==2)|(StatSel[1]&Mode==1)|(StatSel[0]&Mode==0). StatIrq pulses only on the 0→1 edge of StatLine, so overlapping sources block each other.
- Lyc changes are compared continuously; a write that makes Ly==Lyc raises StatLine immediately.
- LcdEnable falling mid-line aborts immediately to the reset state on the next clock, with no irq pulse.

## Timing
- All outputs are registered.
- Mode, Ly and Dot update on the SysCon.CLK edge where ClkEn=1.
- LycMatch, VideoStatus and the locks follow one clock after their inputs.
- StatIrq is asserted one clock after StatLine rises and lasts exactly one SysCon.CLK cycle regardless of ClkEn. VBlankIrq and LineStart follow the same rule.
- Mode3Done is sampled only on ClkEn cycles while Mode==3; it is ignored otherwise.
- Frame length is 70224 ClkEn cycles with default parameters.

## Configuration
- `GBC_LY153_QUIRK_EN` defined: on line TOTAL_LINES-1, Ly reads TOTAL_LINES-1 for dots 0..3, then reads 0. LycMatch uses the displayed Ly.
- Undefined: Ly reads TOTAL_LINES-1 for the whole line.

## Structure
- Package gbc_ppu_pkg contains:
  - ppu_mode_e enum (HBLANK=0, VBLANK=1, OAM_SCAN=2, DRAW=3)
  - default timing constants
  - stat_sel_t packed struct
- One sub-module, gbc_stat_irq_gen: computes StatLine and detects its rising edge. Inputs are Mode, LycMatch and StatSel; output is StatIrq.

## Test plan
- Reset, then LcdEnable=1, Mode3Done tied 1 → line 0: Mode 0 for dots 0..79, Mode 3 at dots 80..251, Mode 0 from dot 252. Line 1 starts in Mode 2 at dot 0.
- Mode3Done held 0 → Mode 3 ends at dot 368 (80+289-1). Mode3Done pulsed at dot 300 → Mode 0 from dot 301.
- Run full frame → VBlankIrq pulses once at Ly=144, dot 0. Ly wraps 153→0 after 70224 ClkEn.
- Lyc=10, StatSel=4'b1000 → StatIrq pulses once at Ly=10, dot 0. With StatSel=4'b1001 and Lyc=10, no second pulse when Mode 0 begins on line 10.
- LcdEnable dropped at Ly=50, Dot=200 → next clock Ly=0, Dot=0, Mode=0, locks low, no StatIrq.
- With GBC_LY153_QUIRK_EN and Lyc=0 → Ly=0 and StatIrq (StatSel=4'b1000) at line 153, dot 4. Without the macro, Ly=153 for the whole line.
